// File: rtl/dice_roller_pkg.sv
// Shared constants for the dice roller: die encodings, side counts, LFSR geometry.
// The top level also has an optional build switch, DICE_ROLL_EDGE_EN (see rtl/dice_roller.sv).
package dice_roller_pkg;

  localparam logic [1:0] DIE_D4  = 2'd0;
  localparam logic [1:0] DIE_D6  = 2'd1;
  localparam logic [1:0] DIE_D8  = 2'd2;
  localparam logic [1:0] DIE_D20 = 2'd3;

  localparam logic [4:0] SIDES_D4  = 5'd4;
  localparam logic [4:0] SIDES_D6  = 5'd6;
  localparam logic [4:0] SIDES_D8  = 5'd8;
  localparam logic [4:0] SIDES_D20 = 5'd20;

  localparam int          LFSR_W            = 16;
  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic logic [4:0] sides_for(input logic [1:0] sel);
    logic [4:0] n;
    n = SIDES_D4;
    case (sel)
      DIE_D4:  n = SIDES_D4;
      DIE_D6:  n = SIDES_D6;
      DIE_D8:  n = SIDES_D8;
      DIE_D20: n = SIDES_D20;
      default: n = SIDES_D4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dice_lfsr.sv
// Free-running 16-bit Galois LFSR (mask 16'hB400) with seed load on reset
// and recovery from the all-zero lock-up state.
module dice_lfsr
  import dice_roller_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_reg;
  logic [LFSR_W-1:0] state_next;

  always_comb begin
    state_next = {1'b0, state_reg[LFSR_W-1:1]} ^ (state_reg[0] ? LFSR_MASK : '0);
    // All-zero is a fixed point of the register; force it back onto the sequence.
    if (state_reg == '0) begin
      state_next = LFSR_SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= LFSR_SEED;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/dice_roller.sv
// Electronic die: scales the LFSR low byte to 1..N on a roll event and holds it.
// Define DICE_ROLL_EDGE_EN to trigger only on rising edges of roll instead of every high cycle.
module dice_roller
  import dice_roller_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] die_select,
  input  logic       roll,
  output logic [7:0] rolled_number
);

  logic [LFSR_W-1:0] lfsr_state;
  logic [4:0]        sides;
  logic [12:0]       product;
  logic [7:0]        face;
  logic              roll_event;
  logic [7:0]        rolled_reg;
  logic              unused_lfsr_hi;

  dice_lfsr #(
    .LFSR_SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .state  (lfsr_state)
  );

  // Only the low byte feeds the scaler; the high byte is pure sequence state.
  assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:8];

  assign sides   = sides_for(die_select);
  assign product = 13'(lfsr_state[7:0]) * 13'(sides);
  assign face    = 8'(product >> 8) + 8'd1;

`ifdef DICE_ROLL_EDGE_EN
  logic roll_prev_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      roll_prev_reg <= 1'b0;
    end else begin
      roll_prev_reg <= roll;
    end
  end

  assign roll_event = roll & ~roll_prev_reg;
`else
  assign roll_event = roll;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rolled_reg <= 8'd0;
    end else if (roll_event) begin
      rolled_reg <= face;
    end
  end

  assign rolled_number = rolled_reg;

endmodule

// File: tb/tb_dice_roller.sv
// Directed self-checking bench for dice_roller; an independent LFSR/scaling
// model supplies every expected face. Inputs change and outputs are sampled on negedge.
module tb_dice_roller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] die_select = 2'd0;
  logic       roll = 1'b0;
  logic [7:0] rolled_number;

  int checks = 0;
  int failures = 0;

  logic [15:0] lfsr_m;
  int          seen [0:20];

  dice_roller dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .die_select   (die_select),
    .roll         (roll),
    .rolled_number(rolled_number)
  );

  always #5 clk = ~clk;

  // Reference LFSR, written from the polynomial description.
  always @(posedge clk) begin
    if (!reset_n) lfsr_m <= 16'hACE1;
    else if (lfsr_m == 16'h0000) lfsr_m <= 16'hACE1;
    else if (lfsr_m[0]) lfsr_m <= (lfsr_m >> 1) ^ 16'hB400;
    else lfsr_m <= lfsr_m >> 1;
  end

  function automatic int sides_of(input logic [1:0] sel);
    case (sel)
      2'd0: return 4;
      2'd1: return 6;
      2'd2: return 8;
      default: return 20;
    endcase
  endfunction

  function automatic logic [7:0] model_face(input logic [7:0] b, input logic [1:0] sel);
    int v;
    v = (int'(b) * sides_of(sel)) / 256 + 1;
    return 8'(v);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle roll pulse followed by one idle cycle; checks model match and range.
  task automatic roll_once(input logic [1:0] sel, output logic [7:0] got);
    logic [7:0] exp;
    die_select = sel;
    roll = 1'b1;
    exp = model_face(lfsr_m[7:0], sel);
    @(negedge clk);
    roll = 1'b0;
    got = rolled_number;
    check("roll_model", {8'd0, rolled_number}, {8'd0, exp});
    check("roll_range", 16'((rolled_number >= 8'd1) && (int'(rolled_number) <= sides_of(sel))), 16'd1);
    $display("roll sel=%0d b=%02h got=%0d exp=%0d", sel, lfsr_m[7:0], rolled_number, exp);
    @(negedge clk);
  endtask

  // Wait (bounded) until the live LFSR low byte equals b, then roll and compare with a hand value.
  task automatic roll_at_byte(input logic [7:0] b, input logic [1:0] sel, input logic [7:0] hand);
    logic [7:0] got;
    int n;
    n = 0;
    while (lfsr_m[7:0] != b && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("spot_found", 16'(n < 5000), 16'd1);
    if (n < 5000) begin
      roll_once(sel, got);
      check("spot_value", {8'd0, got}, {8'd0, hand});
    end
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] held;
    logic [7:0] exp;

    for (int i = 0; i <= 20; i++) seen[i] = 0;

    // Reset for two edges.
    @(negedge clk);
    @(negedge clk);
    check("reset_out", {8'd0, rolled_number}, 16'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("lfsr_first", dut.lfsr_state, 16'hE270);
    check("idle_zero", {8'd0, rolled_number}, 16'd0);
    @(negedge clk);
    check("idle_zero2", {8'd0, rolled_number}, 16'd0);

    // Latency and hold on d4.
    roll_once(2'd0, got);
    held = rolled_number;
    @(negedge clk);
    check("latency_hold", {8'd0, rolled_number}, {8'd0, got});

    // die_select change alone must not alter the output.
    die_select = 2'd3;
    @(negedge clk);
    @(negedge clk);
    check("sel_hold", {8'd0, rolled_number}, {8'd0, held});

    // Hand-computed scaling spot checks.
    roll_at_byte(8'hFF, 2'd3, 8'd20);
    roll_at_byte(8'h00, 2'd3, 8'd1);
    roll_at_byte(8'h80, 2'd1, 8'd4);
    roll_at_byte(8'hFF, 2'd0, 8'd4);

    // Range sweep over random selects.
    for (int i = 0; i < 100; i++) roll_once(2'($urandom_range(0, 3)), got);

    // d20 coverage.
    for (int i = 0; i < 2000; i++) begin
      roll_once(2'd3, got);
      if (got <= 8'd20) seen[got]++;
    end
    for (int f = 1; f <= 20; f++) check("cover_face", 16'(seen[f] > 0), 16'd1);
    check("cover_zero", 16'(seen[0]), 16'd0);

    // Roll held high for five cycles.
    die_select = 2'd1;
    roll = 1'b1;
    held = rolled_number;
    for (int i = 0; i < 5; i++) begin
`ifdef DICE_ROLL_EDGE_EN
      exp = (i == 0) ? model_face(lfsr_m[7:0], 2'd1) : held;
`else
      exp = model_face(lfsr_m[7:0], 2'd1);
`endif
      @(negedge clk);
      if (i == 0) held = exp;
      check("held_roll", {8'd0, rolled_number}, {8'd0, exp});
      $display("held cycle=%0d got=%0d exp=%0d", i, rolled_number, exp);
    end
    roll = 1'b0;
    @(negedge clk);

    // Reset wins over a simultaneous roll.
    roll = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    check("reset_wins", {8'd0, rolled_number}, 16'd0);
    roll = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset", {8'd0, rolled_number}, 16'd0);
    roll_once(2'd2, got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
